// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter for ALU and LSU writeback; WB_RR_EN selects round-robin.
module wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              alu_valid_in,
    input  logic [ADDR_W-1:0] alu_rd_addr_in,
    input  logic [DATA_W-1:0] alu_data_in,
    output logic              alu_ready_out,
    input  logic              lsu_valid_in,
    input  logic [ADDR_W-1:0] lsu_rd_addr_in,
    input  logic [DATA_W-1:0] lsu_data_in,
    output logic              lsu_ready_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic [DATA_W-1:0] rd_data_out,
    output logic [CNT_W-1:0]  conflict_cnt_out
);

    logic contested;
    logic alu_pick;
    logic lsu_pick;

    assign contested = alu_valid_in & lsu_valid_in;

`ifdef WB_RR_EN
    // rr_alu_pref=1 means the ALU is preferred on the next contested cycle
    logic rr_alu_pref;

    always_comb begin
        alu_pick = 1'b0;
        lsu_pick = 1'b0;
        if (contested) begin
            alu_pick = rr_alu_pref;
            lsu_pick = ~rr_alu_pref;
        end else begin
            alu_pick = alu_valid_in;
            lsu_pick = lsu_valid_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_alu_pref <= 1'b0;
        end else if (contested) begin
            rr_alu_pref <= ~rr_alu_pref;
        end
    end
`else
    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       alu_forced;

    assign alu_forced = (wait_cnt == MAX_WAIT_L);

    always_comb begin
        alu_pick = 1'b0;
        lsu_pick = 1'b0;
        if (contested) begin
            alu_pick = alu_forced;
            lsu_pick = ~alu_forced;
        end else begin
            alu_pick = alu_valid_in;
            lsu_pick = lsu_valid_in;
        end
    end

    // Counts consecutive contested losses of a still-pending ALU request
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wait_cnt <= 4'd0;
        end else if (!alu_valid_in || alu_pick) begin
            wait_cnt <= 4'd0;
        end else if (contested) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`endif

    // Ready is forced low during reset so nothing is accepted then
    assign alu_ready_out = rst_in & alu_pick;
    assign lsu_ready_out = rst_in & lsu_pick;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_en_out   <= 1'b0;
            rd_addr_out <= '0;
            rd_data_out <= '0;
        end else if (alu_pick) begin
            wr_en_out   <= (alu_rd_addr_in != '0);
            rd_addr_out <= alu_rd_addr_in;
            rd_data_out <= alu_data_in;
        end else if (lsu_pick) begin
            wr_en_out   <= (lsu_rd_addr_in != '0);
            rd_addr_out <= lsu_rd_addr_in;
            rd_data_out <= lsu_data_in;
        end else begin
            wr_en_out   <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            conflict_cnt_out <= '0;
        end else if (contested && (conflict_cnt_out != {CNT_W{1'b1}})) begin
            conflict_cnt_out <= conflict_cnt_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - table, hand-written and randomized checks of wb_arbiter against a reference model.
module tb_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          alu_valid_in;
    logic [AW-1:0] alu_rd_addr_in;
    logic [DW-1:0] alu_data_in;
    logic          alu_ready_out;
    logic          lsu_valid_in;
    logic [AW-1:0] lsu_rd_addr_in;
    logic [DW-1:0] lsu_data_in;
    logic          lsu_ready_out;
    logic          wr_en_out;
    logic [AW-1:0] rd_addr_out;
    logic [DW-1:0] rd_data_out;
    logic [15:0]   conflict_cnt_out;
    logic          s_alu_ready, s_lsu_ready, s_wr_en;
    logic [AW-1:0] s_rd_addr;
    logic [DW-1:0] s_rd_data;
    logic [1:0]    s_conflict_cnt;

    always #5 clk_in = ~clk_in;

    wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW), .CNT_W(16)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .alu_valid_in(alu_valid_in), .alu_rd_addr_in(alu_rd_addr_in),
        .alu_data_in(alu_data_in), .alu_ready_out(alu_ready_out),
        .lsu_valid_in(lsu_valid_in), .lsu_rd_addr_in(lsu_rd_addr_in),
        .lsu_data_in(lsu_data_in), .lsu_ready_out(lsu_ready_out),
        .wr_en_out(wr_en_out), .rd_addr_out(rd_addr_out),
        .rd_data_out(rd_data_out), .conflict_cnt_out(conflict_cnt_out)
    );

    wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW), .CNT_W(2)) u_small (
        .clk_in(clk_in), .rst_in(rst_in),
        .alu_valid_in(alu_valid_in), .alu_rd_addr_in(alu_rd_addr_in),
        .alu_data_in(alu_data_in), .alu_ready_out(s_alu_ready),
        .lsu_valid_in(lsu_valid_in), .lsu_rd_addr_in(lsu_rd_addr_in),
        .lsu_data_in(lsu_data_in), .lsu_ready_out(s_lsu_ready),
        .wr_en_out(s_wr_en), .rd_addr_out(s_rd_addr),
        .rd_data_out(s_rd_data), .conflict_cnt_out(s_conflict_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_losses;
    bit          m_alu_preferred;
    int          m_conflicts;
    bit          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit          g_alu, g_lsu;
    logic        last_alu_rdy, last_lsu_rdy;

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          lv;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic          e_ardy;
        logic          e_lrdy;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_losses        = 0;
        m_alu_preferred = 1'b0;
        m_conflicts     = 0;
        m_wr            = 1'b0;
        m_addr          = '0;
        m_data          = '0;
        g_alu           = 1'b0;
        g_lsu           = 1'b0;
    endtask

    task automatic model_grant();
        if (alu_valid_in && lsu_valid_in) begin
`ifdef WB_RR_EN
            g_alu = m_alu_preferred;
`else
            g_alu = (m_losses >= MW);
`endif
            g_lsu = !g_alu;
        end else begin
            g_alu = alu_valid_in;
            g_lsu = lsu_valid_in;
        end
    endtask

    task automatic model_commit();
        if (alu_valid_in && lsu_valid_in) begin
            m_conflicts++;
            m_alu_preferred = g_lsu;
        end
        if (!alu_valid_in || g_alu) m_losses = 0;
        else m_losses++;
        if (g_alu) begin
            m_addr = alu_rd_addr_in; m_data = alu_data_in; m_wr = (alu_rd_addr_in != 0);
        end else if (g_lsu) begin
            m_addr = lsu_rd_addr_in; m_data = lsu_data_in; m_wr = (lsu_rd_addr_in != 0);
        end else begin
            m_wr = 1'b0;
        end
    endtask

    // Inputs must already be set (posedge+1); checks ready mid-cycle and outputs after the edge
    task automatic step();
        @(negedge clk_in);
        model_grant();
        last_alu_rdy = alu_ready_out;
        last_lsu_rdy = lsu_ready_out;
        check("alu_ready", alu_ready_out, g_alu);
        check("lsu_ready", lsu_ready_out, g_lsu);
        @(posedge clk_in);
        model_commit();
        #1;
        check("wr_en", wr_en_out, m_wr);
        check("rd_addr", rd_addr_out, m_addr);
        check("rd_data", rd_data_out, m_data);
        check("conflict_cnt", conflict_cnt_out, (m_conflicts > 65535) ? 65535 : m_conflicts);
        check("small_conflict_cnt", s_conflict_cnt, (m_conflicts > 3) ? 3 : m_conflicts);
    endtask

    task automatic idle_inputs();
        alu_valid_in = 1'b0; alu_rd_addr_in = '0; alu_data_in = '0;
        lsu_valid_in = 1'b0; lsu_rd_addr_in = '0; lsu_data_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd3, 32'h1234_5678};
        tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD_BEEF,  1'b0, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF};
        tbl[3] = '{1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 32'h11,        1'b0, 1'b1, 1'b1, 5'd7, 32'h11};
        tbl[4] = '{1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd7, 32'h22};
        tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF};
        tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF};

        // Reset state with requests already pending
        idle_inputs();
        rst_in = 1'b0;
        alu_valid_in = 1'b1; lsu_valid_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_wr_en", wr_en_out, 1'b0);
        check("rst_rd_addr", rd_addr_out, 0);
        check("rst_rd_data", rd_data_out, 0);
        check("rst_conflict_cnt", conflict_cnt_out, 0);
        check("rst_alu_ready", alu_ready_out, 1'b0);
        check("rst_lsu_ready", lsu_ready_out, 1'b0);
        do_reset();

        // Directed table
        for (int i = 0; i < 7; i++) begin
            alu_valid_in = tbl[i].av; alu_rd_addr_in = tbl[i].aa; alu_data_in = tbl[i].ad;
            lsu_valid_in = tbl[i].lv; lsu_rd_addr_in = tbl[i].la; lsu_data_in = tbl[i].ld;
            step();
            check($sformatf("tbl%0d_alu_ready", i), last_alu_rdy, tbl[i].e_ardy);
            check($sformatf("tbl%0d_lsu_ready", i), last_lsu_rdy, tbl[i].e_lrdy);
            check($sformatf("tbl%0d_wr_en", i), wr_en_out, tbl[i].e_wr);
            check($sformatf("tbl%0d_rd_addr", i), rd_addr_out, tbl[i].e_addr);
            check($sformatf("tbl%0d_rd_data", i), rd_data_out, tbl[i].e_data);
        end

        // Continuous contention: policy pattern and counter saturation
        do_reset();
        alu_valid_in = 1'b1; lsu_valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            alu_rd_addr_in = AW'(i + 1);  alu_data_in = 32'hA000_0000 + i;
            lsu_rd_addr_in = AW'(i + 11); lsu_data_in = 32'hB000_0000 + i;
            step();
`ifdef WB_RR_EN
            check($sformatf("rr_lsu_win%0d", i), last_lsu_rdy, (i % 2) == 0);
`else
            check($sformatf("fp_lsu_win%0d", i), last_lsu_rdy, (i % 5) != 4);
`endif
            if (i == 4) begin
                check("conflict_cnt_5", conflict_cnt_out, 5);
                check("small_cnt_saturated", s_conflict_cnt, 3);
            end
        end
        check("conflict_cnt_10", conflict_cnt_out, 10);

        // Reset while an accepted write is on the port
        do_reset();
        alu_valid_in = 1'b1; alu_rd_addr_in = 5'd9; alu_data_in = 32'h9;
        lsu_valid_in = 1'b1; lsu_rd_addr_in = 5'd8; lsu_data_in = 32'h8;
        step();
        lsu_valid_in = 1'b0;
        alu_rd_addr_in = 5'd5; alu_data_in = 32'hAAAA_0001;
        step();
        check("pre_rst_wr_x5", wr_en_out && (rd_addr_out == 5), 1'b1);
        #2 rst_in = 1'b0;
        #1;
        check("midrst_wr_en", wr_en_out, 1'b0);
        check("midrst_conflict_cnt", conflict_cnt_out, 0);
        check("midrst_alu_ready", alu_ready_out, 1'b0);
        @(posedge clk_in); #1;
        check("midrst_hold_wr_en", wr_en_out, 1'b0);
        idle_inputs();
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
        @(posedge clk_in); #1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_x5", wr_en_out, 1'b0);
        end

        // Randomized traffic obeying the valid/payload hold rule
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!alu_valid_in || g_alu) begin
                alu_valid_in   = ($urandom_range(0, 99) < 65);
                alu_rd_addr_in = AW'($urandom_range(0, 31));
                alu_data_in    = $urandom;
            end
            if (!lsu_valid_in || g_lsu) begin
                lsu_valid_in   = ($urandom_range(0, 99) < 65);
                lsu_rd_addr_in = AW'($urandom_range(0, 31));
                lsu_data_in    = $urandom;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
